letter_sequencer: RTL and testbench
===================================

// Module: letter_sequencer
//
// PURPOSE
//   Generates the 4-bit letter code x3..x0 that drives the downstream
//   7-segment letter decoder, stepping through a stored message one
//   character at a time. Characters advance automatically at a fixed tick
//   rate, or manually on a pushbutton press.
//   Sits between board I/O (switch, key) and the combinational decoder.
//
// PARAMETERS
//   TICK_DIV  50_000_000  CLOCK_50 cycles per auto-advance (1 Hz); legal range >= 2
//   MSG_LEN   8           number of characters in the message; legal range 1..16
//   MSG       64'h0       packed message, 4 bits per char; char i = MSG[4*i +: 4]
//
// PORTS
//   CLOCK_50  in   1  system clock; all state changes on the rising edge
//   reset     in   1  synchronous, active-high; overrides every other input
//   run       in   1  level input from a switch: 1 = auto-advance, 0 = hold
//   step      in   1  raw pushbutton, active-high, asynchronous to CLOCK_50
//   code      out  4  current letter code {x3,x2,x1,x0} sent to the decoder
//   blank     out  1  1 = the decoder's display must be forced off (IDLE only)
//   idx       out  4  index of the current character, 0..MSG_LEN-1
//   wrap      out  1  one-cycle pulse when idx advances from MSG_LEN-1 to 0
//
// BEHAVIOUR
//   Reset values
//     - state = IDLE, idx = 0, code = MSG[3:0], blank = 1, wrap = 0
//     - prescaler = 0; step synchroniser flops and edge-detect flop = 0
//   Step input path
//     - step passes through a 2-flop synchroniser, then a rising-edge detector
//     - this produces step_p, a 1-cycle pulse, 3 cycles after the pin rises
//     - holding the button produces exactly one step_p
//   Prescaler
//     - counts 0..TICK_DIV-1 only in RUN; tick = (count == TICK_DIV-1)
//     - on tick the count wraps to 0
//     - forced to 0 in IDLE and HOLD, on entry to RUN, and on any step_p
//   FSM
//     - IDLE: blank = 1, idx held at 0
//         run = 1 -> RUN
//         else step_p -> HOLD (idx stays 0; no advance)
//     - RUN: blank = 0
//         tick or step_p -> advance
//         tick and step_p in the same cycle -> a single advance
//         run = 0 -> HOLD; no advance in that cycle, even if tick is high
//     - HOLD: blank = 0
//         step_p -> advance
//         run = 1 -> RUN; if step_p arrives in the same cycle, it also advances
//   Advance
//     - idx <= (idx == MSG_LEN-1) ? 0 : idx+1
//     - code <= MSG[4*idx_next +: 4] on the same edge, so code is never stale
//     - wrap = 1 for exactly the cycle after a MSG_LEN-1 -> 0 advance
//     - MSG_LEN = 1: every advance keeps idx = 0 and pulses wrap
//   Latency
//     - tick to new code: 1 cycle
//     - step pin rising to new code: 4 cycles
//   Reset mid-operation
//     - any state returns to IDLE on the next edge with reset values
//     - a pending step_p or tick is discarded
//
// TESTING  (TICK_DIV=4, MSG_LEN=3, MSG={4'h2,4'h7,4'h5}: chars 5,7,2)
//   1. reset 2 cycles, run=0, step=0
//        -> blank=1, idx=0, code=5, wrap=0, held indefinitely
//   2. run=1 from IDLE
//        -> blank=0; code sequence 5,7,2,5 with 4 cycles per char
//        -> wrap high for 1 cycle with the second 5
//   3. run=0, step held high 20 cycles
//        -> exactly one advance, 4 cycles after the rise; idx 0->1, code=7
//   4. In RUN, align step_p with tick
//        -> single advance; next tick 4 cycles later
//   5. In RUN at idx=2, assert reset for 1 cycle
//        -> next cycle: IDLE, blank=1, idx=0, code=5, wrap=0; no advance
//   6. MSG_LEN=1, MSG=4'h9, run=1
//        -> code stays 9; wrap pulses every 4 cycles

Source files
------------

// File: rtl/letter_sequencer_if.sv
// Board-side signal bundle for the letter sequencer: run/step controls in,
// letter code and status toward the 7-segment decoder out.
interface letter_sequencer_if;
  logic       run;
  logic       step;
  logic [3:0] code;
  logic       blank;
  logic [3:0] idx;
  logic       wrap;

  modport master (
    output run,
    output step,
    input  code,
    input  blank,
    input  idx,
    input  wrap
  );

  modport slave (
    input  run,
    input  step,
    output code,
    output blank,
    output idx,
    output wrap
  );
endinterface

// File: rtl/letter_sequencer.sv
// Steps a 4-bit letter code through a stored message, on a prescaled tick or a
// synchronised button press; tick-to-code 1 cycle, step pin-to-code 4 cycles.
module letter_sequencer #(
  parameter int          TICK_DIV = 50_000_000,
  parameter int          MSG_LEN  = 8,
  parameter logic [63:0] MSG      = 64'h0
) (
  input logic               CLOCK_50,
  input logic               reset,
  letter_sequencer_if.slave seq
);

  localparam int             CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]  TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [3:0]     LAST_IDX  = 4'(MSG_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    code_q, code_d;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          step_s1_q, step_s2_q, step_s3_q;
  logic          step_p_q;

  logic          tick;
  logic          adv;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      code_q    <= MSG[3:0];
      wrap_q    <= 1'b0;
      cnt_q     <= '0;
      step_s1_q <= 1'b0;
      step_s2_q <= 1'b0;
      step_s3_q <= 1'b0;
      step_p_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      code_q    <= code_d;
      wrap_q    <= wrap_d;
      cnt_q     <= cnt_d;
      step_s1_q <= seq.step;
      step_s2_q <= step_s1_q;
      step_s3_q <= step_s2_q;
      // Registered edge pulse: one cycle per press, regardless of hold time.
      step_p_q  <= step_s2_q & ~step_s3_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    adv     = 1'b0;
    tick    = (state_q == RUN) && (cnt_q == TICK_LAST);

    case (state_q)
      IDLE: begin
        if (seq.run) begin
          state_d = RUN;
        end else if (step_p_q) begin
          state_d = HOLD;
        end
      end
      RUN: begin
        // Leaving RUN wins over a coincident tick or step.
        if (!seq.run) begin
          state_d = HOLD;
        end else begin
          adv = tick | step_p_q;
          if (!adv) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        adv = step_p_q;
        if (seq.run) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    idx_d  = idx_q;
    code_d = code_q;
    wrap_d = 1'b0;
    if (adv) begin
      idx_d  = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
      code_d = MSG[{idx_d, 2'b00} +: 4];
      wrap_d = (idx_q == LAST_IDX);
    end
  end

  assign seq.code  = code_q;
  assign seq.blank = (state_q == IDLE);
  assign seq.idx   = idx_q;
  assign seq.wrap  = wrap_q;

endmodule

// File: tb/tb_letter_sequencer.sv
// Directed scoreboard bench: stimulus pushes per-cycle expectations, a negedge
// monitor pops and compares against both sequencer instances.
module tb_letter_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  letter_sequencer_if bus_a ();
  letter_sequencer_if bus_b ();

  letter_sequencer #(
    .TICK_DIV (4),
    .MSG_LEN  (3),
    .MSG      (64'h275)
  ) dut_a (
    .CLOCK_50 (clk),
    .reset    (reset),
    .seq      (bus_a)
  );

  letter_sequencer #(
    .TICK_DIV (4),
    .MSG_LEN  (1),
    .MSG      (64'h9)
  ) dut_b (
    .CLOCK_50 (clk),
    .reset    (reset),
    .seq      (bus_b)
  );

  typedef struct {
    logic [3:0] code;
    logic       blank;
    logic [3:0] idx;
    logic       wrap;
    string      name;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int checks = 0;
  int errors = 0;

  localparam int A = 0;
  localparam int B = 1;

  task automatic compare(input exp_t e, input logic [3:0] code, input logic blank,
                         input logic [3:0] idx, input logic wrap);
    checks++;
    if ({code, blank, idx, wrap} !== {e.code, e.blank, e.idx, e.wrap}) begin
      errors++;
      $display("FAIL %s: got code=%h blank=%b idx=%0d wrap=%b, expected code=%h blank=%b idx=%0d wrap=%b",
               e.name, code, blank, idx, wrap, e.code, e.blank, e.idx, e.wrap);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      compare(e, bus_a.code, bus_a.blank, bus_a.idx, bus_a.wrap);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      compare(e, bus_b.code, bus_b.blank, bus_b.idx, bus_b.wrap);
    end
  end

  function automatic void push(input int which, input logic [3:0] c, input logic b,
                               input logic [3:0] i, input logic w, input string nm);
    exp_t e;
    e.code  = c;
    e.blank = b;
    e.idx   = i;
    e.wrap  = w;
    e.name  = nm;
    if (which == A) q_a.push_back(e);
    else            q_b.push_back(e);
  endfunction

  // Advance n edges; after each, queue the state expected to be visible until the next edge.
  task automatic step_n(input int n, input int which, input logic [3:0] c, input logic b,
                        input logic [3:0] i, input logic w, input string nm);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      push(which, c, b, i, w, nm);
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus_a.run  = 1'b0;
    bus_a.step = 1'b0;
    bus_b.run  = 1'b0;
    bus_b.step = 1'b0;

    // Reset and idle hold
    step_n(2, A, 4'h5, 1'b1, 4'd0, 1'b0, "reset");
    push(B, 4'h9, 1'b1, 4'd0, 1'b0, "reset_b");
    reset = 1'b0;
    step_n(3, A, 4'h5, 1'b1, 4'd0, 1'b0, "idle_hold");
    push(B, 4'h9, 1'b1, 4'd0, 1'b0, "idle_b");

    // Auto-advance through the message with a wrap
    bus_a.run = 1'b1;
    step_n(4, A, 4'h5, 1'b0, 4'd0, 1'b0, "run_c0");
    step_n(4, A, 4'h7, 1'b0, 4'd1, 1'b0, "run_c1");
    step_n(4, A, 4'h2, 1'b0, 4'd2, 1'b0, "run_c2");
    step_n(1, A, 4'h5, 1'b0, 4'd0, 1'b1, "run_wrap");
    step_n(3, A, 4'h5, 1'b0, 4'd0, 1'b0, "run_after_wrap");

    // Drop run while a tick is due: go to HOLD without advancing
    bus_a.run = 1'b0;
    step_n(1, A, 4'h5, 1'b0, 4'd0, 1'b0, "hold_entry_no_adv");

    // Held button gives exactly one advance, 4 cycles after the rise
    bus_a.step = 1'b1;
    step_n(3, A, 4'h5, 1'b0, 4'd0, 1'b0, "step_sync");
    step_n(17, A, 4'h7, 1'b0, 4'd1, 1'b0, "step_once");
    bus_a.step = 1'b0;
    step_n(4, A, 4'h7, 1'b0, 4'd1, 1'b0, "step_release");

    // Step pulse coinciding with a tick gives a single advance
    bus_a.run = 1'b1;
    step_n(1, A, 4'h7, 1'b0, 4'd1, 1'b0, "run_reentry");
    bus_a.step = 1'b1;
    step_n(3, A, 4'h7, 1'b0, 4'd1, 1'b0, "align_pre");
    bus_a.step = 1'b0;
    step_n(4, A, 4'h2, 1'b0, 4'd2, 1'b0, "align_single");
    step_n(1, A, 4'h5, 1'b0, 4'd0, 1'b1, "align_next_tick");
    step_n(3, A, 4'h5, 1'b0, 4'd0, 1'b0, "run_c0b");
    step_n(4, A, 4'h7, 1'b0, 4'd1, 1'b0, "run_c1b");
    step_n(4, A, 4'h2, 1'b0, 4'd2, 1'b0, "pre_reset");

    // Reset at idx 2 with a tick pending
    reset     = 1'b1;
    bus_a.run = 1'b0;
    step_n(1, A, 4'h5, 1'b1, 4'd0, 1'b0, "mid_reset");
    reset = 1'b0;
    step_n(3, A, 4'h5, 1'b1, 4'd0, 1'b0, "post_reset_idle");

    // Step from IDLE enters HOLD without advancing
    bus_a.step = 1'b1;
    step_n(1, A, 4'h5, 1'b1, 4'd0, 1'b0, "idle_step_sync");
    bus_a.step = 1'b0;
    step_n(2, A, 4'h5, 1'b1, 4'd0, 1'b0, "idle_step_sync");
    step_n(2, A, 4'h5, 1'b0, 4'd0, 1'b0, "idle_to_hold");

    // Single-character message: code fixed, wrap every tick
    bus_b.run = 1'b1;
    step_n(4, B, 4'h9, 1'b0, 4'd0, 1'b0, "m1_first");
    for (int r = 0; r < 3; r++) begin
      step_n(1, B, 4'h9, 1'b0, 4'd0, 1'b1, "m1_wrap");
      step_n(3, B, 4'h9, 1'b0, 4'd0, 1'b0, "m1_between");
    end

    @(negedge clk);
    #1;
    checks++;
    if (q_a.size() + q_b.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q_a.size() + q_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
